// File: rtl/branch_resolve_unit_if.sv
// EX-stage branch resolution bus: comparator handshake, redirect request to fetch,
// squash control and branch statistics.
interface branch_resolve_unit_if #(
    parameter int CNT_W = 16
) ();
    logic             ex_valid;
    logic             ex_is_branch;
    logic             ex_is_jal;
    logic             ex_is_jalr;
    logic [2:0]       ex_funct3;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_imm;
    logic [31:0]      ex_rs1;
    logic             BrEq;
    logic             BrLT;
    logic             BrUn;
    logic             redirect_valid;
    logic             redirect_ready;
    logic [31:0]      redirect_pc;
    logic             flush;
    logic             misalign_err;
    logic             illegal_br;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport slave (
        input  ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
               ex_pc, ex_imm, ex_rs1, BrEq, BrLT, redirect_ready,
        output BrUn, redirect_valid, redirect_pc, flush, misalign_err,
               illegal_br, branch_cnt, taken_cnt
    );

    modport master (
        output ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
               ex_pc, ex_imm, ex_rs1, BrEq, BrLT, redirect_ready,
        input  BrUn, redirect_valid, redirect_pc, flush, misalign_err,
               illegal_br, branch_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage branches/jumps, issues a registered PC redirect to fetch,
// squashes younger instructions and keeps saturating branch statistics.
//
//   state      | meaning
//   S_IDLE     | sampling EX instructions, no redirect outstanding
//   S_REDIRECT | redirect_valid/flush held until fetch accepts
//   S_FLUSH    | flush held for FLUSH_CYCLES cycles after acceptance
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_resolve_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_FLUSH    = 2'd2
    } state_t;

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = (FLUSH_CYCLES > 0) ? FC_W'(FLUSH_CYCLES - 1) : '0;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [FC_W-1:0]   r_flush_cnt;
    logic [31:0]       r_redirect_pc;
    logic              r_misalign;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_branch_cnt;
    logic [CNT_W-1:0]  r_taken_cnt;

    logic              w_sel_jalr;
    logic              w_sel_jal;
    logic              w_sel_br;
    logic              w_illegal;
    logic              w_cond;
    logic              w_taken;
    logic [31:0]       w_jalr_sum;
    logic [31:0]       w_target;
    logic              w_sample;
    logic              w_go;
    logic              w_accept;

    // JALR outranks JAL, which outranks a B-type flag
    assign w_sel_jalr = bus.ex_is_jalr;
    assign w_sel_jal  = bus.ex_is_jal & ~bus.ex_is_jalr;
    assign w_sel_br   = bus.ex_is_branch & ~bus.ex_is_jal & ~bus.ex_is_jalr;
    assign w_illegal  = w_sel_br & (bus.ex_funct3[2:1] == 2'b01);

    always_comb begin
        w_cond = 1'b0;
        case (bus.ex_funct3)
            3'b000:         w_cond = bus.BrEq;
            3'b001:         w_cond = ~bus.BrEq;
            3'b100, 3'b110: w_cond = bus.BrLT;
            3'b101, 3'b111: w_cond = ~bus.BrLT;
            default:        w_cond = 1'b0;
        endcase
    end

    assign w_taken    = w_sel_jalr | w_sel_jal | (w_sel_br & w_cond);
    assign w_jalr_sum = bus.ex_rs1 + bus.ex_imm;
    assign w_target   = w_sel_jalr ? {w_jalr_sum[31:1], 1'b0} : (bus.ex_pc + bus.ex_imm);
    assign w_sample   = (r_state == S_IDLE) & bus.ex_valid;
    assign w_go       = w_sample & w_taken & ~w_target[1];
    assign w_accept   = (r_state == S_REDIRECT) & bus.redirect_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go)
                    w_state_nxt = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (w_accept)
                    w_state_nxt = (FLUSH_CYCLES > 0) ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: begin
                if (r_flush_cnt == '0)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Loaded with FLUSH_CYCLES-1 so S_FLUSH lasts exactly FLUSH_CYCLES cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_cnt <= '0;
        end else if (w_accept) begin
            r_flush_cnt <= FC_LOAD;
        end else if ((r_state == S_FLUSH) && (r_flush_cnt != '0)) begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_pc <= '0;
            r_misalign    <= 1'b0;
            r_illegal     <= 1'b0;
        end else begin
            r_misalign <= w_sample & w_taken & w_target[1];
            r_illegal  <= w_sample & w_illegal;
            if (w_go)
                r_redirect_pc <= w_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else if (w_sample & w_sel_br & ~w_illegal) begin
            if (r_branch_cnt != '1)
                r_branch_cnt <= r_branch_cnt + 1'b1;
            if (w_cond && (r_taken_cnt != '1))
                r_taken_cnt <= r_taken_cnt + 1'b1;
        end
    end

    assign bus.BrUn           = (bus.ex_funct3[2:1] == 2'b11);
    assign bus.redirect_valid = (r_state == S_REDIRECT);
    assign bus.flush          = (r_state != S_IDLE);
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.misalign_err   = r_misalign;
    assign bus.illegal_br     = r_illegal;
    assign bus.branch_cnt     = r_branch_cnt;
    assign bus.taken_cnt      = r_taken_cnt;
endmodule
